// File: rtl/d_latch_bank.sv
// rtl/d_latch_bank.sv - parameterised bank of level-sensitive D storage cells on a complementary clock pair
//
// Purpose:
//   WIDTH independent storage bits clocked by the pair clk / clk_bar.
//   MODE 0: one latch per bit, transparent while clk=1.
//   MODE 1: master-slave pair per bit. The master is transparent while clk=0
//           and the slave while clk=1, so the bank acts as a rising-edge register.
//   When clk == clk_bar (including X/Z on either input), all storage holds
//   and clk_err is raised.
//
// Ports:
//   clk      in   1      clock phase; high = transparent phase of the output latch
//   clk_bar  in   1      complementary clock phase, nominally ~clk
//   rst_n    in   1      asynchronous active-low reset; loads RESET_VAL into all storage
//   d        in   WIDTH  data in
//   q_bar    out  WIDTH  inverted stored data
//   q        out  WIDTH  stored data, always exactly ~q_bar
//   clk_err  out  1      high while clk == clk_bar

`timescale 1ns/1ps

module d_latch_bank #(
  parameter int unsigned      WIDTH     = 1,
  parameter int unsigned      MODE      = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             clk_bar,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q_bar,
  output logic [WIDTH-1:0] q,
  output logic             clk_err
);

  // Case equality makes X/Z on either clock input fall into the invalid
  // phase, so storage holds instead of going unknown.
  logic open_ph;
  logic closed_ph;

  assign open_ph   = (clk === 1'b1) && (clk_bar === 1'b0);
  assign closed_ph = (clk === 1'b0) && (clk_bar === 1'b1);
  assign clk_err   = ~(open_ph | closed_ph);

  // Value seen by the outputs. This is the only latch in MODE 0 and the
  // slave latch in MODE 1.
  logic [WIDTH-1:0] stored;

  generate
    if (MODE == 0) begin : g_single
      // Reset is checked first so that it dominates transparency. On release
      // during the open phase, the latch re-evaluates and picks up d at once.
      always_latch begin
        if (!rst_n) begin
          stored <= RESET_VAL;
        end else if (open_ph) begin
          stored <= d;
        end
      end
    end else begin : g_master_slave
      logic [WIDTH-1:0] master;

      // The master and slave are never transparent together, so d cannot
      // race through to q while clk is high.
      always_latch begin
        if (!rst_n) begin
          master <= RESET_VAL;
        end else if (closed_ph) begin
          master <= d;
        end
      end

      always_latch begin
        if (!rst_n) begin
          stored <= RESET_VAL;
        end else if (open_ph) begin
          stored <= master;
        end
      end
    end
  endgenerate

  // q is derived from q_bar so the two outputs can never disagree.
  assign q_bar = ~stored;
  assign q     = ~q_bar;

endmodule

// File: tb/tb_d_latch_bank.sv
// tb/tb_d_latch_bank.sv - self-checking bench for d_latch_bank in single-latch and master-slave modes

`timescale 1ns/1ps

module tb_d_latch_bank;

  logic       clk;
  logic       clk_bar;
  logic       rst_n;
  logic [3:0] d_a;
  logic [7:0] d_b;
  logic       d_c;
  logic [7:0] d_d;

  logic [3:0] q_a, q_bar_a;
  logic [7:0] q_b, q_bar_b;
  logic       q_c, q_bar_c;
  logic [7:0] q_d, q_bar_d;
  logic       clk_err_a, clk_err_b, clk_err_c, clk_err_d;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model state
  logic [3:0] m_a;
  logic [7:0] m_b;
  logic [7:0] m_b_closed_d;  // last d_b seen during a closed phase (since reset)
  logic       m_c;
  logic [7:0] m_d;
  logic       m_err;
  bit         prev_open = 1'b0;

  d_latch_bank #(.WIDTH(4), .MODE(0), .RESET_VAL(4'h5)) u_a (
    .clk(clk), .clk_bar(clk_bar), .rst_n(rst_n), .d(d_a),
    .q_bar(q_bar_a), .q(q_a), .clk_err(clk_err_a)
  );

  d_latch_bank #(.WIDTH(8), .MODE(1), .RESET_VAL(8'h3C)) u_b (
    .clk(clk), .clk_bar(clk_bar), .rst_n(rst_n), .d(d_b),
    .q_bar(q_bar_b), .q(q_b), .clk_err(clk_err_b)
  );

  d_latch_bank #(.WIDTH(1), .MODE(0), .RESET_VAL(1'b0)) u_c (
    .clk(clk), .clk_bar(clk_bar), .rst_n(rst_n), .d(d_c),
    .q_bar(q_bar_c), .q(q_c), .clk_err(clk_err_c)
  );

  d_latch_bank #(.WIDTH(8), .MODE(0), .RESET_VAL(8'h00)) u_d (
    .clk(clk), .clk_bar(clk_bar), .rst_n(rst_n), .d(d_d),
    .q_bar(q_bar_d), .q(q_d), .clk_err(clk_err_d)
  );

  // Behavioural rules: MODE 0 stores d while open. MODE 1 outputs the d
  // value last seen in a closed phase, taken when an open phase begins.
  // Reset forces everything to RESET_VAL.
  task automatic model_update();
    bit op;
    bit cl;
    op    = (clk == 1'b1) && (clk_bar == 1'b0);
    cl    = (clk == 1'b0) && (clk_bar == 1'b1);
    m_err = !(op || cl);
    if (!rst_n) begin
      m_a          = 4'h5;
      m_b          = 8'h3C;
      m_b_closed_d = 8'h3C;
      m_c          = 1'b0;
      m_d          = 8'h00;
    end else begin
      if (op) begin
        m_a = d_a;
        m_c = d_c;
        m_d = d_d;
        if (!prev_open) m_b = m_b_closed_d;
      end
      if (cl) m_b_closed_d = d_b;
    end
    prev_open = op;
  endtask

  task automatic apply(input logic c, input logic cb, input logic r);
    clk     = c;
    clk_bar = cb;
    rst_n   = r;
    model_update();
    #1;
  endtask

  task automatic test_reset();
    d_a = 4'hF; d_b = 8'hFF; d_c = 1'b1; d_d = 8'hFF;
    apply(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) apply(~clk, clk, 1'b0);
      else       apply(1'b1, 1'b0, 1'b0);
      total_cnt++;
      if (q_a !== 4'h5) $display("FAIL reset_q_a step %0d got %h exp 5", i, q_a);
      else pass_cnt++;
      total_cnt++;
      if (q_bar_a !== 4'hA) $display("FAIL reset_q_bar_a step %0d got %h exp a", i, q_bar_a);
      else pass_cnt++;
      total_cnt++;
      if (q_b !== 8'h3C) $display("FAIL reset_q_b step %0d got %h exp 3c", i, q_b);
      else pass_cnt++;
    end
    apply(1'b1, 1'b0, 1'b1);
    total_cnt++;
    if (q_bar_a !== 4'h0) $display("FAIL release_open_q_bar_a got %h exp 0", q_bar_a);
    else pass_cnt++;
    total_cnt++;
    if (q_b !== 8'h3C) $display("FAIL release_open_q_b got %h exp 3c", q_b);
    else pass_cnt++;
  endtask

  task automatic test_transparency();
    logic [3:0] seq;
    seq = 4'b1010;  // d values applied: 0,1,0,1
    for (int i = 0; i < 4; i++) begin
      d_c = seq[i];
      apply(1'b1, 1'b0, 1'b1);
      total_cnt++;
      if (q_bar_c !== ~seq[i]) $display("FAIL transparent_q_bar step %0d got %b exp %b", i, q_bar_c, ~seq[i]);
      else pass_cnt++;
    end
    apply(1'b0, 1'b1, 1'b1);
    seq = 4'b0101;  // d values during closed phase: 1,0,1
    for (int i = 0; i < 3; i++) begin
      d_c = seq[i];
      apply(1'b0, 1'b1, 1'b1);
      total_cnt++;
      if (q_bar_c !== 1'b0) $display("FAIL closed_hold_q_bar step %0d got %b exp 0", i, q_bar_c);
      else pass_cnt++;
    end
  endtask

  task automatic test_hold_to_open();
    d_c = 1'b0;
    apply(1'b0, 1'b1, 1'b1);
    total_cnt++;
    if (q_bar_c !== 1'b0) $display("FAIL hold_before_open got %b exp 0", q_bar_c);
    else pass_cnt++;
    apply(1'b1, 1'b0, 1'b1);
    total_cnt++;
    if (q_bar_c !== 1'b1) $display("FAIL reopen_q_bar got %b exp 1", q_bar_c);
    else pass_cnt++;
  endtask

  task automatic test_mode1_edge();
    apply(1'b0, 1'b1, 1'b1);
    d_b = 8'h01;
    apply(1'b0, 1'b1, 1'b1);
    apply(1'b1, 1'b0, 1'b1);
    total_cnt++;
    if (q_b !== 8'h01) $display("FAIL ms_rise_capture got %h exp 01", q_b);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      d_b = 8'(i & 1);
      apply(1'b1, 1'b0, 1'b1);
      total_cnt++;
      if (q_b !== 8'h01) $display("FAIL ms_high_block step %0d got %h exp 01", i, q_b);
      else pass_cnt++;
    end
    d_b = 8'h00;
    apply(1'b1, 1'b0, 1'b1);
    apply(1'b0, 1'b1, 1'b1);
    total_cnt++;
    if (q_b !== 8'h01) $display("FAIL ms_low_hold got %h exp 01", q_b);
    else pass_cnt++;
    apply(1'b1, 1'b0, 1'b1);
    total_cnt++;
    if (q_b !== 8'h00) $display("FAIL ms_second_rise got %h exp 00", q_b);
    else pass_cnt++;
  endtask

  task automatic test_clk_err();
    d_a = 4'h3;
    apply(1'b1, 1'b0, 1'b1);
    total_cnt++;
    if (clk_err_a !== 1'b0) $display("FAIL clk_err_valid got %b exp 0", clk_err_a);
    else pass_cnt++;
    apply(1'b1, 1'b1, 1'b1);
    total_cnt++;
    if (clk_err_a !== 1'b1) $display("FAIL clk_err_both_high got %b exp 1", clk_err_a);
    else pass_cnt++;
    d_a = 4'hC;
    apply(1'b1, 1'b1, 1'b1);
    total_cnt++;
    if (q_a !== 4'h3) $display("FAIL clk_err_hold_q_a got %h exp 3", q_a);
    else pass_cnt++;
    apply(1'b0, 1'b0, 1'b1);
    d_a = 4'h9;
    apply(1'b0, 1'b0, 1'b1);
    total_cnt++;
    if (clk_err_b !== 1'b1) $display("FAIL clk_err_both_low got %b exp 1", clk_err_b);
    else pass_cnt++;
    total_cnt++;
    if (q_a !== 4'h3) $display("FAIL clk_err_low_hold_q_a got %h exp 3", q_a);
    else pass_cnt++;
    apply(1'b1, 1'b0, 1'b1);
    total_cnt++;
    if (clk_err_a !== 1'b0) $display("FAIL clk_err_restored got %b exp 0", clk_err_a);
    else pass_cnt++;
    total_cnt++;
    if (q_a !== 4'h9) $display("FAIL resume_follow_q_a got %h exp 9", q_a);
    else pass_cnt++;
    apply(1'b1, 1'b1, 1'b0);
    total_cnt++;
    if (clk_err_c !== 1'b1) $display("FAIL clk_err_in_reset got %b exp 1", clk_err_c);
    else pass_cnt++;
    apply(1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_multibit();
    d_d = 8'hA5;
    apply(1'b1, 1'b0, 1'b1);
    total_cnt++;
    if (q_bar_d !== 8'h5A) $display("FAIL mb_open got %h exp 5a", q_bar_d);
    else pass_cnt++;
    apply(1'b0, 1'b1, 1'b1);
    d_d = 8'h5A;
    apply(1'b0, 1'b1, 1'b1);
    total_cnt++;
    if (q_bar_d !== 8'h5A) $display("FAIL mb_closed_hold got %h exp 5a", q_bar_d);
    else pass_cnt++;
    apply(1'b1, 1'b0, 1'b1);
    total_cnt++;
    if (q_bar_d !== 8'hA5) $display("FAIL mb_reopen got %h exp a5", q_bar_d);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int sel;
    apply(1'b0, 1'b1, 1'b0);
    apply(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 19);
      if (sel < 8) begin
        d_a = 4'($urandom); d_b = 8'($urandom); d_c = 1'($urandom); d_d = 8'($urandom);
        apply(clk, clk_bar, rst_n);
      end else if (sel < 16) begin
        apply(~clk, clk, rst_n);
      end else if (sel < 18) begin
        apply(clk, clk, rst_n);
      end else if (!rst_n || sel == 19) begin
        apply(clk, clk_bar, ~rst_n);
      end else begin
        apply(clk, clk_bar, rst_n);
      end
      total_cnt++;
      if (q_a !== m_a) $display("FAIL rand_q_a step %0d got %h exp %h", i, q_a, m_a);
      else pass_cnt++;
      total_cnt++;
      if (q_b !== m_b) $display("FAIL rand_q_b step %0d got %h exp %h", i, q_b, m_b);
      else pass_cnt++;
      total_cnt++;
      if (q_bar_b !== ~m_b) $display("FAIL rand_q_bar_b step %0d got %h exp %h", i, q_bar_b, ~m_b);
      else pass_cnt++;
      total_cnt++;
      if (q_c !== m_c) $display("FAIL rand_q_c step %0d got %b exp %b", i, q_c, m_c);
      else pass_cnt++;
      total_cnt++;
      if (q_bar_d !== ~m_d) $display("FAIL rand_q_bar_d step %0d got %h exp %h", i, q_bar_d, ~m_d);
      else pass_cnt++;
      total_cnt++;
      if (clk_err_d !== m_err) $display("FAIL rand_clk_err step %0d got %b exp %b", i, clk_err_d, m_err);
      else pass_cnt++;
    end
  endtask

  initial begin
    clk = 1'b0; clk_bar = 1'b1; rst_n = 1'b0;
    d_a = '0; d_b = '0; d_c = 1'b0; d_d = '0;
    model_update();
    #1;
    test_reset();
    test_transparency();
    test_hold_to_open();
    test_mode1_edge();
    test_clk_err();
    test_multibit();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
